// File: rtl/trade_buffer.sv
// trade_buffer: captures parser 'P' trade records into a FIFO,
// tags each with a sequence number, counts drops, keeps totals.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   field_valid       one-cycle parser pulse qualifying msg fields
//   msg_type          parser message type (TRADE_TYPE captured)
//   order_id/price/   trade record fields
//   volume
//   out_valid/ready   head-of-FIFO valid/ready handshake
//   out_order_id,     head record fields and sequence tag
//   out_price,
//   out_volume,
//   out_seq
//   count             occupancy, 0..DEPTH
//   overflow_cnt      saturating dropped-trade count
//   total_volume      sum of accepted volumes, mod 2^64
//   notional_sum      sum of accepted price*volume, mod 2^64
module trade_buffer #(
    parameter int          DEPTH      = 16,
    parameter logic [7:0]  TRADE_TYPE = 8'h50,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          field_valid,
    input  logic [7:0]    msg_type,
    input  logic [63:0]   order_id,
    input  logic [31:0]   price,
    input  logic [31:0]   volume,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_order_id,
    output logic [31:0]   out_price,
    output logic [31:0]   out_volume,
    output logic [31:0]   out_seq,
    output logic [AW:0]   count,
    output logic [15:0]   overflow_cnt,
    output logic [63:0]   total_volume,
    output logic [63:0]   notional_sum
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [63:0]   ord_mem [DEPTH];
    logic [31:0]   prc_mem [DEPTH];
    logic [31:0]   vol_mem [DEPTH];
    logic [31:0]   seq_mem [DEPTH];

    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   seq_q, seq_d;
    logic [15:0]   ovf_q, ovf_d;
    logic [63:0]   tvol_q, tvol_d;
    logic [63:0]   ntl_q, ntl_d;

    logic          trade;
    logic          pop;
    logic          push;
    logic          drop;
    logic [63:0]   prod;

    assign trade = field_valid && (msg_type == TRADE_TYPE);
    assign out_valid = (cnt_q != '0);
    assign pop = out_valid && out_ready;
    // A same-cycle pop frees the slot, so a full FIFO still accepts.
    assign push = trade && ((cnt_q != FULL) || pop);
    assign drop = trade && !push;
    assign prod = 64'(price) * 64'(volume);

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        seq_d  = seq_q;
        ovf_d  = ovf_q;
        tvol_d = tvol_q;
        ntl_d  = ntl_q;

        // Dropped trades still consume a sequence number.
        if (trade) begin
            seq_d = seq_q + 32'd1;
        end
        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
        if (push) begin
            wr_d   = wr_q + AW'(1);
            tvol_d = tvol_q + 64'(volume);
            ntl_d  = ntl_q + prod;
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            seq_q  <= '0;
            ovf_q  <= '0;
            tvol_q <= '0;
            ntl_q  <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            seq_q  <= seq_d;
            ovf_q  <= ovf_d;
            tvol_q <= tvol_d;
            ntl_q  <= ntl_d;
        end
    end

    // Storage is never cleared; occupancy gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            ord_mem[wr_q] <= order_id;
            prc_mem[wr_q] <= price;
            vol_mem[wr_q] <= volume;
            seq_mem[wr_q] <= seq_q;
        end
    end

    assign out_order_id = out_valid ? ord_mem[rd_q] : '0;
    assign out_price    = out_valid ? prc_mem[rd_q] : '0;
    assign out_volume   = out_valid ? vol_mem[rd_q] : '0;
    assign out_seq      = out_valid ? seq_mem[rd_q] : '0;

    assign count        = cnt_q;
    assign overflow_cnt = ovf_q;
    assign total_volume = tvol_q;
    assign notional_sum = ntl_q;

endmodule
